// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: serial transmitter state encoding and datapath width.
package mu0_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BIT_CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/mu0_baud_cnt.sv
// Baud counter: counts TERM_CNT cycles per bit, wraps on its own tick,
// and is held at zero while i_clr is high.
module mu0_baud_cnt #(
  parameter int unsigned TERM_CNT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (TERM_CNT > 1) ? $clog2(TERM_CNT) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CNT_W'(TERM_CNT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mu0_serial_tx16.sv
// 16-bit serial transmitter: start bit, 16 data bits LSB first, stop bit,
// each lasting CLKS_PER_BIT cycles, with a valid/ready word handshake.
module mu0_serial_tx16
  import mu0_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [DATA_W-1:0] D,
  output logic              Ready,
  output logic              TxD,
  output logic              Busy,
  output logic              Done
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      w_shift_d;
  logic [DATA_W-1:0]      w_shift_nv;
  logic                   w_shift_en;
  logic [BIT_CNT_W-1:0]   r_bit;
  logic [BIT_CNT_W-1:0]   w_bit_next;
  logic                   r_txd;
  logic                   w_txd_next;
  logic                   w_tick;
  logic                   w_baud_clr;

  // Counter idles at zero so the START bit gets a full bit period.
  assign w_baud_clr = (r_state == IDLE);

  mu0_baud_cnt #(
    .TERM_CNT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_clr    (w_baud_clr),
    .o_tick_c (w_tick)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_bit   <= w_bit_next;
      r_txd   <= w_txd_next;
    end
  end

  // Enable-gated load register holding the word being shifted out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= w_shift_d;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_shift_d    = r_shift;
    w_bit_next   = r_bit;
    w_txd_next   = 1'b1;

    case (r_state)
      IDLE: begin
        if (Valid) begin
          w_state_next = START;
          w_shift_en   = 1'b1;
          w_shift_d    = D;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          w_shift_d  = {1'b0, r_shift[DATA_W-1:1]};
          w_bit_next = r_bit + BIT_CNT_W'(1);
          if (r_bit == '1) begin
            w_state_next = STOP;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    w_shift_nv = w_shift_en ? w_shift_d : r_shift;

    // Line level is registered from the state being entered.
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_shift_nv[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  assign Ready = (r_state == IDLE);
  assign Busy  = ~Ready;
  assign Done  = (r_state == STOP) && w_tick;
  assign TxD   = r_txd;

endmodule

// File: tb/tb_mu0_serial_tx16.sv
// Randomised and directed checks of mu0_serial_tx16 at CLKS_PER_BIT=4 and =1
// against a frame-level expected-waveform model.
module tb_mu0_serial_tx16;

  typedef struct packed {
    logic txd;
    logic done;
    logic idle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid [2];
  logic [15:0] d     [2];
  logic        ready [2];
  logic        txd   [2];
  logic        busy  [2];
  logic        done  [2];

  int   n_chk;
  int   n_pass;
  int   cyc;
  exp_t q0 [$];
  exp_t q1 [$];
  bit   m_ready [2];
  logic [2:0] rec0 [$];
  logic [2:0] rec1 [$];

  always #5 clk = ~clk;

  mu0_serial_tx16 #(.CLKS_PER_BIT(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .Valid(valid[0]), .D(d[0]),
    .Ready(ready[0]), .TxD(txd[0]), .Busy(busy[0]), .Done(done[0])
  );

  mu0_serial_tx16 #(.CLKS_PER_BIT(1)) u_dut1 (
    .Clk(clk), .Reset(rst), .Valid(valid[1]), .D(d[1]),
    .Ready(ready[1]), .TxD(txd[1]), .Busy(busy[1]), .Done(done[1])
  );

  function automatic int cpb_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input int i, input logic got, input logic want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s inst%0d cyc=%0d got=%b want=%b", nm, i, cyc, got, want);
  endtask

  // Expected line waveform of one whole frame, one entry per clock cycle.
  task automatic push_frame(input int i, input logic [15:0] w);
    exp_t e;
    logic lv;
    for (int b = 0; b < 18; b++) begin
      if (b == 0)       lv = 1'b0;
      else if (b == 17) lv = 1'b1;
      else              lv = w[b-1];
      for (int c = 0; c < cpb_of(i); c++) begin
        e.txd  = lv;
        e.done = (b == 17) && (c == cpb_of(i) - 1);
        e.idle = 1'b0;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  function automatic exp_t pop_exp(input int i);
    exp_t e;
    e.txd  = 1'b1;
    e.done = 1'b0;
    e.idle = 1'b1;
    if (i == 0 && q0.size() > 0) e = q0.pop_front();
    if (i == 1 && q1.size() > 0) e = q1.pop_front();
    return e;
  endfunction

  task automatic check_outputs(input int i, input exp_t e);
    chk("txd",   i, txd[i],   e.txd);
    chk("done",  i, done[i],  e.done);
    chk("ready", i, ready[i], e.idle);
    chk("busy",  i, busy[i],  ~e.idle);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst && valid[i] && m_ready[i]) push_frame(i, d[i]);
    end
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      e = pop_exp(i);
      check_outputs(i, e);
      m_ready[i] = e.idle;
    end
    rec0.push_back({txd[0], done[0], ready[0]});
    rec1.push_back({txd[1], done[1], ready[1]});
  endtask

  // Asynchronous reset between edges; outputs must be idle before the next edge.
  task automatic reset_mid();
    exp_t e;
    #2 rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    e.txd  = 1'b1;
    e.done = 1'b0;
    e.idle = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_outputs(i, e);
      m_ready[i] = 1'b1;
    end
  endtask

  task automatic pin(input string nm, input int i, input int k, input int f, input logic want);
    logic [2:0] r;
    r = (i == 0) ? rec0[k] : rec1[k];
    chk(nm, i, r[f], want);
  endtask

  task automatic clear_rec();
    rec0.delete();
    rec1.delete();
  endtask

  initial begin
    logic [17:0] lv;
    int          nd0;
    int          nd1;
    logic [2:0]  r;
    exp_t        e;

    n_chk   = 0;
    n_pass  = 0;
    cyc     = 0;
    rst     = 1'b1;
    valid   = '{1'b0, 1'b0};
    d       = '{16'h0, 16'h0};
    m_ready = '{1'b1, 1'b1};
    e.txd   = 1'b1;
    e.done  = 1'b0;
    e.idle  = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i, e);

    // Valid during reset must not start a frame.
    valid = '{1'b1, 1'b1};
    repeat (3) step();
    rst   = 1'b0;
    valid = '{1'b0, 1'b0};
    repeat (2) step();

    // Single frame A5C3 (and FFFF at one cycle per bit).
    d     = '{16'hA5C3, 16'hFFFF};
    valid = '{1'b1, 1'b1};
    clear_rec();
    step();
    valid = '{1'b0, 1'b0};
    repeat (79) step();
    lv = 18'b1_1010_0101_1100_0011_0;
    for (int k = 0; k < 72; k++) begin
      pin("a5c3_txd",  0, k, 2, lv[k/4]);
      pin("a5c3_done", 0, k, 1, k == 71);
    end
    pin("a5c3_ready_last_stop", 0, 71, 0, 1'b0);
    pin("a5c3_ready_after",     0, 72, 0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      pin("ffff_txd",  1, k, 2, k != 0);
      pin("ffff_done", 1, k, 1, k == 17);
    end
    pin("ffff_ready_after", 1, 18, 0, 1'b1);

    // Back-to-back frames with Valid held high.
    d     = '{16'h0001, 16'h0001};
    valid = '{1'b1, 1'b1};
    clear_rec();
    step();
    d = '{16'h8000, 16'h8000};
    repeat (150) step();
    valid = '{1'b0, 1'b0};
    repeat (80) step();
    pin("b2b_f1_bit0",     0, 4,   2, 1'b1);
    pin("b2b_f1_bit1",     0, 8,   2, 1'b0);
    pin("b2b_gap_txd",     0, 72,  2, 1'b1);
    pin("b2b_gap_ready",   0, 72,  0, 1'b1);
    pin("b2b_f2_start",    0, 73,  2, 1'b0);
    pin("b2b_f2_ready",    0, 73,  0, 1'b0);
    pin("b2b_f2_bit0",     0, 77,  2, 1'b0);
    pin("b2b_f2_bit15",    0, 137, 2, 1'b1);
    pin("b2b_f2_gap",      0, 145, 0, 1'b1);
    pin("b2b1_gap_ready",  1, 18,  0, 1'b1);
    pin("b2b1_f2_start",   1, 19,  2, 1'b0);
    pin("b2b1_f2_bit0",    1, 20,  2, 1'b0);
    pin("b2b1_f2_bit15",   1, 35,  2, 1'b1);

    // D changes right after acceptance; frame keeps the captured word.
    d     = '{16'h0000, 16'h0000};
    valid = '{1'b1, 1'b1};
    clear_rec();
    step();
    d     = '{16'hFFFF, 16'hFFFF};
    valid = '{1'b0, 1'b0};
    repeat (75) step();
    for (int k = 4; k < 68; k++) pin("dchg_data", 0, k, 2, 1'b0);
    for (int k = 1; k < 17; k++) pin("dchg_data", 1, k, 2, 1'b0);

    // Valid pulses while busy are neither accepted nor queued.
    d     = '{16'h1234, 16'h1234};
    valid = '{1'b1, 1'b1};
    clear_rec();
    step();
    valid = '{1'b0, 1'b0};
    step();
    valid = '{1'b1, 1'b1};
    step();
    valid = '{1'b0, 1'b0};
    repeat (10) step();
    valid = '{1'b1, 1'b1};
    step();
    valid = '{1'b0, 1'b0};
    repeat (70) step();
    nd0 = 0;
    nd1 = 0;
    for (int k = 0; k < rec0.size(); k++) begin
      r = rec0[k];
      nd0 += int'(r[1]);
      r = rec1[k];
      nd1 += int'(r[1]);
    end
    chk("pulse_one_done", 0, nd0 == 1, 1'b1);
    chk("pulse_one_done", 1, nd1 == 1, 1'b1);

    // Reset during data bit 5 abandons the frame.
    d     = '{16'h5A5A, 16'h0000};
    valid = '{1'b1, 1'b0};
    step();
    valid = '{1'b0, 1'b0};
    repeat (25) step();
    reset_mid();
    valid = '{1'b1, 1'b1};
    repeat (3) step();
    rst   = 1'b0;
    valid = '{1'b0, 1'b0};
    clear_rec();
    repeat (40) step();
    for (int k = 0; k < 40; k++) pin("post_reset_txd", 0, k, 2, 1'b1);

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        valid[i] = ($urandom_range(0, 3) == 0);
        d[i]     = 16'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset_mid();
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end
      step();
    end
    valid = '{1'b0, 1'b0};
    repeat (100) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mu0_serial_tx16.md
MU0_SERIAL_TX16 -- requirements
Module: mu0_serial_tx16

Interface
REQ-001 Parameter: CLKS_PER_BIT, 4, Clk cycles per serial bit; legal range 1..65535.
REQ-002 Port: Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: Valid  input  1  requester has a word on D to transmit.
REQ-005 Port: D  input  16  parallel word to transmit.
REQ-006 Port: Ready  output  1  transmitter idle and able to accept a word.
REQ-007 Port: TxD  output  1  serial line; idles high.
REQ-008 Port: Busy  output  1  frame in progress; equals NOT Ready.
REQ-009 Port: Done  output  1  single-cycle pulse marking frame completion.

Function
REQ-010 The block SHALL use four states: IDLE, START, DATA, STOP.
REQ-011 Ready SHALL be high only in IDLE, decoded directly from state with no added latency.
REQ-012 The block SHALL accept a word at a rising Clk edge where Valid=1 and Ready=1, capture D into an internal 16-bit shift register, and enter START.
REQ-013 After acceptance, D and Valid SHALL be ignored until the next IDLE; changing D mid-frame SHALL NOT alter the frame.
REQ-014 TxD SHALL be registered: 1 in IDLE, 0 in START, the current data bit in DATA, 1 in STOP.
REQ-015 Each of START, every data bit, and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every bit boundary.
REQ-016 Data bits SHALL be sent LSB first, D[0] through D[15], with the shift register shifting right once per bit boundary.
REQ-017 A 4-bit bit counter SHALL index data bits; the transition DATA->STOP SHALL occur at the end of bit 15 (counter wraps 15->0).
REQ-018 The frame SHALL occupy exactly 18*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-019 Done SHALL be high for exactly the last cycle of STOP; the state SHALL be IDLE (Ready=1) in the following cycle.
REQ-020 With Valid held high continuously, consecutive frames SHALL be separated by exactly one IDLE cycle with TxD=1.
REQ-021 CLKS_PER_BIT=1 SHALL give one cycle per bit with no other behavioural change.
REQ-022 Valid asserted while Busy=1 SHALL have no effect and SHALL NOT be queued.

Reset
REQ-023 Reset=1 SHALL immediately, without waiting for Clk, force state IDLE, TxD=1, Ready=1, Busy=0, Done=0, and clear the shift register, bit counter and baud counter.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release, no remaining bits of that frame SHALL be sent.
REQ-025 While Reset=1, Valid SHALL NOT be accepted.

Structure
REQ-026 A shared package mu0_pkg SHALL hold the state encoding (2-bit, IDLE=0, START=1, DATA=2, STOP=3) and the data-width constant 16.
REQ-027 The baud counter SHALL be a single sub-module, mu0_baud_cnt: parameterised terminal count, clear input, and a single-cycle tick output.
REQ-028 The 16-bit shift register SHALL be implemented inline using the same enable-gated load style as the existing MU0 16-bit register.

Verification
REQ-029 Reset mid-operation: assert Reset during DATA bit 5 -> TxD=1, Ready=1 and Done=0 within the same cycle; after release, TxD stays 1.
REQ-030 Single frame, CLKS_PER_BIT=4, D=16'hA5C3 -> TxD reads 0, then C3 LSB-first (1,1,0,0,0,0,1,1), then A5 LSB-first (1,0,1,0,0,1,0,1), then 1, each level held 4 cycles; Done pulses in cycle 72; Ready rises in cycle 73.
REQ-031 Back-to-back, Valid held high, D=16'h0001 then 16'h8000 -> two 72-cycle frames separated by one TxD=1 IDLE cycle, with correct bit order in each.
REQ-032 D changed to 16'hFFFF one cycle after accepting 16'h0000 -> all 16 transmitted data bits are 0.
REQ-033 Valid pulsed during START and DATA of a frame carrying 16'h1234 -> exactly one frame sent and one Done pulse.
REQ-034 CLKS_PER_BIT=1, D=16'hFFFF -> 18-cycle frame: one 0 cycle, seventeen 1 cycles; Done in cycle 18.
